// File: rtl/cache_port_arbiter.sv
// Shares one cache controller port between fetch (I) and memory-stage (D) requesters; D wins unless I has waited STARVE_LIMIT grants.
// Hit latency: grant at request edge, one ACCESS cycle, done/rdata the cycle after; accesses abort after TIMEOUT busy cycles.
module cache_port_arbiter #(
    parameter int STARVE_LIMIT = 3,
    parameter int TIMEOUT      = 63
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_done,
    output logic        if_stall,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        mem_done,
    output logic        mem_stall,
    output logic        cc_req,
    output logic [31:0] cc_addr,
    output logic [31:0] cc_data,
    output logic        cc_mode,
    input  logic [31:0] cc_rdata,
    input  logic        cc_wait,
    output logic        timeout_err
);

    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
    localparam int WAIT_W   = $clog2(TIMEOUT + 1);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t              state;
    logic                grantI;
    logic [STARVE_W-1:0] starveCnt;
    logic [WAIT_W-1:0]   waitCnt;
    logic                grantD;
    logic                finish;

    assign grantD = mem_req && (!if_req || (starveCnt < STARVE_W'(STARVE_LIMIT)));
    // Access ends on a hit or when the busy budget is exhausted this cycle.
    assign finish = !cc_wait || (waitCnt == WAIT_W'(TIMEOUT - 1));

    assign if_stall  = if_req & ~if_done;
    assign mem_stall = mem_req & ~mem_done;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            grantI      <= 1'b0;
            starveCnt   <= '0;
            waitCnt     <= '0;
            cc_req      <= 1'b0;
            cc_addr     <= '0;
            cc_data     <= '0;
            cc_mode     <= 1'b0;
            if_rdata    <= '0;
            mem_rdata   <= '0;
            if_done     <= 1'b0;
            mem_done    <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            if_done  <= 1'b0;
            mem_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (grantD) begin
                        state   <= ACCESS;
                        grantI  <= 1'b0;
                        cc_req  <= 1'b1;
                        cc_addr <= mem_addr;
                        cc_data <= mem_wdata;
                        cc_mode <= mem_we;
                        waitCnt <= '0;
                        if (if_req) begin
                            starveCnt <= starveCnt + 1'b1;
                        end
                    end else if (if_req) begin
                        state     <= ACCESS;
                        grantI    <= 1'b1;
                        cc_req    <= 1'b1;
                        cc_addr   <= if_addr;
                        cc_mode   <= 1'b0;
                        waitCnt   <= '0;
                        starveCnt <= '0;
                    end
                end
                ACCESS: begin
                    if (finish) begin
                        state  <= IDLE;
                        cc_req <= 1'b0;
                        if (grantI) begin
                            if_done <= 1'b1;
                        end else begin
                            mem_done <= 1'b1;
                        end
                        // An aborted access returns no data to either port.
                        if (cc_wait) begin
                            timeout_err <= 1'b1;
                        end else if (grantI) begin
                            if_rdata <= cc_rdata;
                        end else if (!cc_mode) begin
                            mem_rdata <= cc_rdata;
                        end
                    end else begin
                        waitCnt <= waitCnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_port_arbiter.sv
// Directed bench for cache_port_arbiter: reset, hit, miss, contention, store, timeout, reset mid-access.
module tb_cache_port_arbiter;

    logic        clk;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_done;
    logic        if_stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_done;
    logic        mem_stall;
    logic        cc_req;
    logic [31:0] cc_addr;
    logic [31:0] cc_data;
    logic        cc_mode;
    logic [31:0] cc_rdata;
    logic        cc_wait;
    logic        timeout_err;

    int vecs = 0;
    int errs = 0;

    localparam logic [31:0] C_DATA = 32'hA5A5_0000;

    cache_port_arbiter #(.STARVE_LIMIT(3), .TIMEOUT(63)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done), .if_stall(if_stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_done(mem_done), .mem_stall(mem_stall),
        .cc_req(cc_req), .cc_addr(cc_addr), .cc_data(cc_data), .cc_mode(cc_mode),
        .cc_rdata(cc_rdata), .cc_wait(cc_wait), .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; if_req = 1'b0; mem_req = 1'b1; mem_we = 1'b1;
        if_addr = 32'h4; mem_addr = 32'h8; mem_wdata = 32'hC; cc_rdata = 32'h1; cc_wait = 1'b0;
        #2 rst = 1'b0;
        #1;
        vecs++; if ({cc_req, cc_mode, if_done, mem_done, timeout_err} !== 5'b0) begin
            errs++; $display("FAIL reset_ctrl got %b want 00000", {cc_req, cc_mode, if_done, mem_done, timeout_err});
        end
        vecs++; if (cc_addr !== 32'h0 || cc_data !== 32'h0) begin
            errs++; $display("FAIL reset_cc got addr=%h data=%h want 0/0", cc_addr, cc_data);
        end
        vecs++; if (if_rdata !== 32'h0 || mem_rdata !== 32'h0) begin
            errs++; $display("FAIL reset_rdata got if=%h mem=%h want 0/0", if_rdata, mem_rdata);
        end
        cyc(); cyc();
        vecs++; if (cc_req !== 1'b0) begin
            errs++; $display("FAIL reset_hold_noreq got %b want 0", cc_req);
        end
        mem_req = 1'b0; mem_we = 1'b0;
        rst = 1'b1;
        cyc();
        vecs++; if (cc_req !== 1'b0 || mem_done !== 1'b0) begin
            errs++; $display("FAIL reset_release_idle got req=%b done=%b want 0/0", cc_req, mem_done);
        end
    endtask

    task automatic test_load_hit();
        cyc();
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h100; cc_wait = 1'b0; cc_rdata = 32'hDEADBEEF;
        #1;
        vecs++; if (mem_stall !== 1'b1 || cc_req !== 1'b0) begin
            errs++; $display("FAIL hit_req_cycle got stall=%b req=%b want 1/0", mem_stall, cc_req);
        end
        cyc();
        vecs++; if (cc_req !== 1'b1 || cc_addr !== 32'h100 || cc_mode !== 1'b0 || mem_done !== 1'b0) begin
            errs++; $display("FAIL hit_access got req=%b addr=%h mode=%b done=%b want 1/100/0/0", cc_req, cc_addr, cc_mode, mem_done);
        end
        cyc();
        vecs++; if (mem_done !== 1'b1 || mem_rdata !== 32'hDEADBEEF || cc_req !== 1'b0 || if_done !== 1'b0) begin
            errs++; $display("FAIL hit_done got done=%b rdata=%h req=%b if_done=%b want 1/deadbeef/0/0", mem_done, mem_rdata, cc_req, if_done);
        end
        vecs++; if (mem_stall !== 1'b0) begin
            errs++; $display("FAIL hit_stall_drop got %b want 0", mem_stall);
        end
        mem_req = 1'b0;
        cyc();
        vecs++; if (mem_done !== 1'b0 || cc_req !== 1'b0) begin
            errs++; $display("FAIL hit_after got done=%b req=%b want 0/0", mem_done, cc_req);
        end
    endtask

    task automatic test_idle_drop();
        cyc();
        mem_req = 1'b1; if_req = 1'b1;
        #2;
        mem_req = 1'b0; if_req = 1'b0;
        cyc();
        vecs++; if (cc_req !== 1'b0) begin
            errs++; $display("FAIL idle_drop got req=%b want 0", cc_req);
        end
    endtask

    task automatic test_miss();
        int  stallCnt;
        bit  bad;
        stallCnt = 0; bad = 1'b0;
        cyc();
        if_req = 1'b1; if_addr = 32'h40; cc_wait = 1'b1; cc_rdata = 32'h0;
        #1;
        if (if_stall) stallCnt++;
        for (int i = 0; i < 5; i++) begin
            cyc();
            if (if_stall) stallCnt++;
            if (cc_req !== 1'b1 || if_done !== 1'b0 || cc_addr !== 32'h40) bad = 1'b1;
            if (i == 1) begin if_addr = 32'h999; mem_req = 1'b1; end
            if (i == 3) mem_req = 1'b0;
        end
        cyc();
        cc_wait = 1'b0; cc_rdata = 32'h00500013;
        #1;
        if (if_stall) stallCnt++;
        vecs++; if (bad || cc_req !== 1'b1 || cc_addr !== 32'h40 || cc_mode !== 1'b0) begin
            errs++; $display("FAIL miss_hold got bad=%b req=%b addr=%h mode=%b want 0/1/40/0", bad, cc_req, cc_addr, cc_mode);
        end
        cyc();
        if (if_stall) stallCnt++;
        vecs++; if (if_done !== 1'b1 || if_rdata !== 32'h00500013 || mem_done !== 1'b0) begin
            errs++; $display("FAIL miss_done got done=%b rdata=%h mem_done=%b want 1/00500013/0", if_done, if_rdata, mem_done);
        end
        vecs++; if (timeout_err !== 1'b0) begin
            errs++; $display("FAIL miss_no_timeout got %b want 0", timeout_err);
        end
        if_req = 1'b0;
        cyc();
        vecs++; if (stallCnt != 7) begin
            errs++; $display("FAIL miss_stall_cycles got %0d want 7", stallCnt);
        end
        vecs++; if (if_done !== 1'b0 || cc_req !== 1'b0) begin
            errs++; $display("FAIL miss_after got done=%b req=%b want 0/0", if_done, cc_req);
        end
    endtask

    task automatic test_contention();
        int         n;
        logic [7:0] seq;
        bit         both;
        n = 0; seq = 8'h0; both = 1'b0;
        cyc();
        mem_req = 1'b1; if_req = 1'b1; mem_we = 1'b0; if_addr = 32'h80; mem_addr = 32'h300;
        cc_wait = 1'b0; cc_rdata = C_DATA;
        for (int c = 0; c < 40 && n < 8; c++) begin
            cyc();
            if (if_done && mem_done) both = 1'b1;
            if (if_done || mem_done) begin
                seq[n] = if_done;
                n++;
                if (n == 8) begin if_req = 1'b0; mem_req = 1'b0; end
            end
        end
        vecs++; if (n != 8) begin
            errs++; $display("FAIL cont_count got %0d accesses want 8", n);
        end
        vecs++; if (seq !== 8'b1000_1000) begin
            errs++; $display("FAIL cont_order got %b want 10001000 (bit0 first, 1=I)", seq);
        end
        vecs++; if (both) begin
            errs++; $display("FAIL cont_dual_done got 1 want 0");
        end
        vecs++; if (if_rdata !== C_DATA || mem_rdata !== C_DATA) begin
            errs++; $display("FAIL cont_rdata got if=%h mem=%h want %h", if_rdata, mem_rdata, C_DATA);
        end
        cyc();
        vecs++; if (cc_req !== 1'b0) begin
            errs++; $display("FAIL cont_after got req=%b want 0", cc_req);
        end
    endtask

    task automatic test_store();
        cyc();
        mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h200; mem_wdata = 32'h12345678;
        cc_wait = 1'b0; cc_rdata = 32'hFFFF0000;
        cyc();
        vecs++; if (cc_req !== 1'b1 || cc_mode !== 1'b1 || cc_data !== 32'h12345678 || cc_addr !== 32'h200) begin
            errs++; $display("FAIL store_access got req=%b mode=%b data=%h addr=%h want 1/1/12345678/200", cc_req, cc_mode, cc_data, cc_addr);
        end
        cyc();
        vecs++; if (mem_done !== 1'b1 || mem_rdata !== C_DATA) begin
            errs++; $display("FAIL store_done got done=%b rdata=%h want 1/%h", mem_done, mem_rdata, C_DATA);
        end
        mem_req = 1'b0; mem_we = 1'b0;
    endtask

    task automatic test_timeout();
        int accessCnt;
        bit gotDone;
        bit early;
        bit ifPulse;
        accessCnt = 0; gotDone = 1'b0; early = 1'b0; ifPulse = 1'b0;
        cyc();
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h500; cc_wait = 1'b1; cc_rdata = 32'hBAD0BAD0;
        for (int c = 0; c < 150 && !gotDone; c++) begin
            cyc();
            if (cc_req) accessCnt++;
            if (cc_req && timeout_err) early = 1'b1;
            if (if_done) ifPulse = 1'b1;
            if (mem_done) gotDone = 1'b1;
        end
        mem_req = 1'b0;
        vecs++; if (!gotDone) begin
            errs++; $display("FAIL timeout_done got no done within 150 cycles want done");
        end
        vecs++; if (accessCnt != 63) begin
            errs++; $display("FAIL timeout_len got %0d access cycles want 63", accessCnt);
        end
        vecs++; if (timeout_err !== 1'b1 || early) begin
            errs++; $display("FAIL timeout_err got err=%b early=%b want 1/0", timeout_err, early);
        end
        vecs++; if (mem_rdata !== C_DATA || ifPulse) begin
            errs++; $display("FAIL timeout_rdata got rdata=%h if_pulse=%b want %h/0", mem_rdata, ifPulse, C_DATA);
        end
        cc_wait = 1'b0;
        cyc(); cyc();
        vecs++; if (timeout_err !== 1'b1) begin
            errs++; $display("FAIL timeout_sticky got %b want 1", timeout_err);
        end
    endtask

    task automatic test_reset_mid_access();
        bit bad;
        bad = 1'b0;
        cyc();
        if_req = 1'b1; if_addr = 32'h40; cc_wait = 1'b1; cc_rdata = 32'h11112222;
        cyc(); cyc(); cyc();
        vecs++; if (cc_req !== 1'b1) begin
            errs++; $display("FAIL rstmid_pre got req=%b want 1", cc_req);
        end
        rst = 1'b0;
        #1;
        vecs++; if ({cc_req, cc_mode, if_done, mem_done, timeout_err} !== 5'b0 || cc_addr !== 32'h0 || cc_data !== 32'h0) begin
            errs++; $display("FAIL rstmid_ctrl got %b addr=%h data=%h want 00000/0/0", {cc_req, cc_mode, if_done, mem_done, timeout_err}, cc_addr, cc_data);
        end
        vecs++; if (if_rdata !== 32'h0 || mem_rdata !== 32'h0) begin
            errs++; $display("FAIL rstmid_rdata got if=%h mem=%h want 0/0", if_rdata, mem_rdata);
        end
        cc_wait = 1'b0;
        for (int i = 0; i < 2; i++) begin
            cyc();
            if (if_done !== 1'b0 || cc_req !== 1'b0) bad = 1'b1;
        end
        vecs++; if (bad) begin
            errs++; $display("FAIL rstmid_held got activity during reset want none");
        end
        rst = 1'b1;
        cyc();
        vecs++; if (cc_req !== 1'b1 || cc_addr !== 32'h40 || if_done !== 1'b0) begin
            errs++; $display("FAIL rstmid_regrant got req=%b addr=%h done=%b want 1/40/0", cc_req, cc_addr, if_done);
        end
        cyc();
        vecs++; if (if_done !== 1'b1 || if_rdata !== 32'h11112222 || timeout_err !== 1'b0) begin
            errs++; $display("FAIL rstmid_done got done=%b rdata=%h err=%b want 1/11112222/0", if_done, if_rdata, timeout_err);
        end
        if_req = 1'b0;
        cyc();
        vecs++; if (if_done !== 1'b0 || cc_req !== 1'b0) begin
            errs++; $display("FAIL rstmid_after got done=%b req=%b want 0/0", if_done, cc_req);
        end
    endtask

    initial begin
        test_reset();
        test_load_hit();
        test_idle_drop();
        test_miss();
        test_contention();
        test_store();
        test_timeout();
        test_reset_mid_access();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not complete within 100000 time units");
        $fatal(1);
    end

endmodule
